// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and scan output payloads.
package vga_timing_pkg;

    localparam int unsigned VGA_CLK_DIV  = 4;

    localparam int unsigned VGA_H_VIS    = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int unsigned VGA_V_VIS    = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    localparam int unsigned PRE_W  = 4;
    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 10;
    localparam int unsigned POSX_W = 10;
    localparam int unsigned POSY_W = 9;

    // Registered scan outputs decoded from the counters.
    typedef struct packed {
        logic [POSX_W-1:0] pollx;
        logic [POSY_W-1:0] polly;
        logic              active;
        logic              hsync;
        logic              vsync;
        logic              tick;
        logic              frame;
    } scan_out_t;

    // Sync/active copies delayed one more clk for downstream hit logic.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } scan_dly_t;

    localparam scan_out_t SCAN_OUT_RST = '{
        pollx:  '0,
        polly:  '0,
        active: 1'b0,
        hsync:  1'b1,
        vsync:  1'b1,
        tick:   1'b0,
        frame:  1'b0
    };

    localparam scan_dly_t SCAN_DLY_RST = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

    // Half-open window test: lo <= val < hi.
    function automatic logic in_range(input int unsigned val,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Enabled wrap counter used for both the horizontal and vertical scan axes.
module scan_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned WIDTH = HCNT_W,
    parameter int unsigned WRAP  = VGA_H_TOTAL - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count_q,
    output logic             wrap_c
);

    logic [WIDTH-1:0] count_d;
    logic             at_wrap;

    // Next count: advance on enable, return to zero at (or past) the wrap value.
    always_comb begin
        at_wrap = (count_q >= WIDTH'(WRAP));
        wrap_c  = en & at_wrap;
        count_d = count_q;
        if (en) begin
            count_d = at_wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel prescaler, H/V counters, registered position/sync.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = VGA_CLK_DIV,
    parameter int unsigned H_VIS   = VGA_H_VIS,
    parameter int unsigned H_FP    = VGA_H_FP,
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BP    = VGA_H_BP,
    parameter int unsigned V_VIS   = VGA_V_VIS,
    parameter int unsigned V_FP    = VGA_V_FP,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BP    = VGA_V_BP
) (
    input  logic              clk,
    input  logic              reset,
    output logic [POSX_W-1:0] PollX,
    output logic [POSY_W-1:0] PollY,
    output logic              Active,
    output logic              PixelTick,
    output logic              FrameStart,
    output logic              HSyncD,
    output logic              VSyncD,
    output logic              ActiveD
);

    localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic              tick_c;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              h_wrap_c;
    logic              v_wrap_c;
    scan_out_t         out_q;
    scan_out_t         out_d;
    scan_dly_t         dly_q;
    scan_dly_t         dly_d;

    // Pixel prescaler: tick on the last clk of each pixel period.
    always_comb begin
        tick_c = (pre_q >= PRE_W'(CLK_DIV - 1));
        pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    scan_counter #(
        .WIDTH (HCNT_W),
        .WRAP  (H_TOTAL - 1)
    ) u_hcount (
        .clk     (clk),
        .reset   (reset),
        .en      (tick_c),
        .count_q (hcount),
        .wrap_c  (h_wrap_c)
    );

    // Vertical axis only moves on the tick that ends a line.
    scan_counter #(
        .WIDTH (VCNT_W),
        .WRAP  (V_TOTAL - 1)
    ) u_vcount (
        .clk     (clk),
        .reset   (reset),
        .en      (h_wrap_c),
        .count_q (vcount),
        .wrap_c  (v_wrap_c)
    );

    // Decode the current counter position into the output payload.
    always_comb begin
        out_d        = SCAN_OUT_RST;
        out_d.active = (hcount < HCNT_W'(H_VIS)) && (vcount < VCNT_W'(V_VIS));
        out_d.pollx  = out_d.active ? POSX_W'(hcount) : '0;
        out_d.polly  = out_d.active ? POSY_W'(vcount) : '0;
        out_d.hsync  = !in_range(32'(hcount), H_SYNC_START, H_SYNC_END);
        out_d.vsync  = !in_range(32'(vcount), V_SYNC_START, V_SYNC_END);
        out_d.tick   = tick_c;
        out_d.frame  = v_wrap_c;

        dly_d        = SCAN_DLY_RST;
        dly_d.hsync  = out_q.hsync;
        dly_d.vsync  = out_q.vsync;
        dly_d.active = out_q.active;
    end

    // Output and delayed-sync registers; reset forces idle sync levels immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= SCAN_OUT_RST;
            dly_q <= SCAN_DLY_RST;
        end else begin
            out_q <= out_d;
            dly_q <= dly_d;
        end
    end

    assign PollX      = out_q.pollx;
    assign PollY      = out_q.polly;
    assign Active     = out_q.active;
    assign PixelTick  = out_q.tick;
    assign FrameStart = out_q.frame;
    assign HSyncD     = dly_q.hsync;
    assign VSyncD     = dly_q.vsync;
    assign ActiveD    = dly_q.active;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: default-timing instance for line-level checks, scaled instance for frames.
module tb_vga_scan_gen;

    logic clk;
    logic rst_d;
    logic rst_s;
    int   checks;
    int   failures;
    int   n_d;
    int   n_s;

    logic [9:0] px_d, px_s;
    logic [8:0] py_d, py_s;
    logic act_d, tick_d, fs_d, hsd_d, vsd_d, actd_d;
    logic act_s, tick_s, fs_s, hsd_s, vsd_s, actd_s;
    logic [24:0] obs_d, obs_s;

    localparam logic [24:0] RST_VEC = {10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    assign obs_d = {px_d, py_d, act_d, tick_d, fs_d, hsd_d, vsd_d, actd_d};
    assign obs_s = {px_s, py_s, act_s, tick_s, fs_s, hsd_s, vsd_s, actd_s};

    vga_scan_gen dut_d (
        .clk(clk), .reset(rst_d),
        .PollX(px_d), .PollY(py_d), .Active(act_d), .PixelTick(tick_d),
        .FrameStart(fs_d), .HSyncD(hsd_d), .VSyncD(vsd_d), .ActiveD(actd_d)
    );

    // Small raster: H 12/2/3/3 (total 20), V 6/2/2/2 (total 12), 3 clks per pixel.
    vga_scan_gen #(
        .CLK_DIV(3),
        .H_VIS(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6),  .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .reset(rst_s),
        .PollX(px_s), .PollY(py_s), .Active(act_s), .PixelTick(tick_s),
        .FrameStart(fs_s), .HSyncD(hsd_s), .VSyncD(vsd_s), .ActiveD(actd_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in clk n (n=1 is the first clk after reset release).
    function automatic logic [24:0] exp_vec(input int n, input bit sel);
        int d, hv, hfp, hs, hbp, vv, vfp, vs, vbp, ht, vt, h, v, hp, vp;
        logic act, tick, fs, hsd, vsd, actd;
        logic [9:0] px;
        logic [8:0] py;
        if (sel) begin
            d = 3; hv = 12; hfp = 2; hs = 3; hbp = 3; vv = 6; vfp = 2; vs = 2; vbp = 2;
        end else begin
            d = 4; hv = 640; hfp = 16; hs = 96; hbp = 48; vv = 480; vfp = 10; vs = 2; vbp = 33;
        end
        ht   = hv + hfp + hs + hbp;
        vt   = vv + vfp + vs + vbp;
        h    = ((n - 1) / d) % ht;
        v    = ((n - 1) / (d * ht)) % vt;
        act  = (h < hv) && (v < vv);
        px   = act ? 10'(h) : 10'd0;
        py   = act ? 9'(v) : 9'd0;
        tick = ((n % d) == 0);
        fs   = ((n % (d * ht * vt)) == 0);
        if (n <= 1) begin
            hsd = 1'b1; vsd = 1'b1; actd = 1'b0;
        end else begin
            hp   = ((n - 2) / d) % ht;
            vp   = ((n - 2) / (d * ht)) % vt;
            hsd  = !((hp >= hv + hfp) && (hp < hv + hfp + hs));
            vsd  = !((vp >= vv + vfp) && (vp < vv + vfp + vs));
            actd = (hp < hv) && (vp < vv);
        end
        return {px, py, act, tick, fs, hsd, vsd, actd};
    endfunction

    // Advance one clk and sample 1 time unit after the edge.
    task automatic step();
        logic rd, rs;
        rd = rst_d;
        rs = rst_s;
        @(posedge clk);
        #1;
        n_d = rd ? 0 : n_d + 1;
        n_s = rs ? 0 : n_s + 1;
    endtask

    task automatic test_reset();
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) step();
        checks++;
        if (obs_d !== RST_VEC) begin
            failures++;
            $display("FAIL reset_default got=%h exp=%h", obs_d, RST_VEC);
        end
        checks++;
        if (obs_s !== RST_VEC) begin
            failures++;
            $display("FAIL reset_scaled got=%h exp=%h", obs_s, RST_VEC);
        end
    endtask

    task automatic test_pixel_tick();
        logic [7:0] tick_exp;
        logic [7:0] px_exp;
        tick_exp = 8'b1000_1000;
        px_exp   = 8'b1111_0000;
        rst_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (tick_d !== tick_exp[i]) begin
                failures++;
                $display("FAIL pixel_tick clk=%0d got=%b exp=%b", i + 1, tick_d, tick_exp[i]);
            end
            checks++;
            if ({px_d, py_d, act_d} !== {10'(px_exp[i]), 9'd0, 1'b1}) begin
                failures++;
                $display("FAIL first_pos clk=%0d got=x%0d y%0d a%b exp=x%0d y0 a1",
                         i + 1, px_d, py_d, act_d, px_exp[i]);
            end
        end
    endtask

    task automatic test_line();
        int hs_low, hs_first, act_fall;
        logic [24:0] e;
        hs_low = 0; hs_first = 0; act_fall = 0;
        while (n_d < 3208) begin
            step();
            e = exp_vec(n_d, 1'b0);
            checks++;
            if (obs_d !== e) begin
                failures++;
                $display("FAIL line_vec n=%0d got=%h exp=%h", n_d, obs_d, e);
            end
            if (hsd_d === 1'b0) begin
                hs_low++;
                if (hs_first == 0) hs_first = n_d;
            end
            if (act_d === 1'b0 && act_fall == 0) act_fall = n_d;
            if (n_d == 2560) begin
                checks++;
                if ({px_d, py_d, act_d} !== {10'd639, 9'd0, 1'b1}) begin
                    failures++;
                    $display("FAIL last_visible_x got=x%0d a%b exp=x639 a1", px_d, act_d);
                end
            end
            if (n_d == 2561) begin
                checks++;
                if ({px_d, act_d} !== {10'd0, 1'b0}) begin
                    failures++;
                    $display("FAIL blank_after_640 got=x%0d a%b exp=x0 a0", px_d, act_d);
                end
            end
            if (n_d == 3201) begin
                checks++;
                if ({px_d, py_d, act_d} !== {10'd0, 9'd1, 1'b1}) begin
                    failures++;
                    $display("FAIL line1_start got=x%0d y%0d a%b exp=x0 y1 a1", px_d, py_d, act_d);
                end
            end
        end
        checks++;
        if (hs_low != 384) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=384", hs_low);
        end
        checks++;
        if (hs_first != 2626) begin
            failures++;
            $display("FAIL hsync_start got=%0d exp=2626", hs_first);
        end
        checks++;
        if (act_fall != 2561) begin
            failures++;
            $display("FAIL active_fall got=%0d exp=2561", act_fall);
        end
    endtask

    task automatic test_reset_mid_line();
        int hs_first;
        logic [24:0] e;
        hs_first = 0;
        while (n_d < 6002) step();
        checks++;
        if (hsd_d !== 1'b0) begin
            failures++;
            $display("FAIL inside_hsync_h700 got=%b exp=0", hsd_d);
        end
        rst_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_d !== RST_VEC) begin
                failures++;
                $display("FAIL midline_reset clk=%0d got=%h exp=%h", i, obs_d, RST_VEC);
            end
        end
        rst_d = 1'b0;
        while (n_d < 2700) begin
            step();
            e = exp_vec(n_d, 1'b0);
            checks++;
            if (obs_d !== e) begin
                failures++;
                $display("FAIL restart_vec n=%0d got=%h exp=%h", n_d, obs_d, e);
            end
            if (hsd_d === 1'b0 && hs_first == 0) hs_first = n_d;
        end
        checks++;
        if (hs_first != 2626) begin
            failures++;
            $display("FAIL restart_hsync_start got=%0d exp=2626", hs_first);
        end
    endtask

    task automatic test_last_pixel();
        rst_s = 1'b0;
        while (n_s < 337) begin
            step();
            if (n_s == 334 || n_s == 336) begin
                checks++;
                if ({px_s, py_s, act_s} !== {10'd11, 9'd5, 1'b1}) begin
                    failures++;
                    $display("FAIL corner_pixel n=%0d got=x%0d y%0d a%b exp=x11 y5 a1",
                             n_s, px_s, py_s, act_s);
                end
            end
            if (n_s == 336) begin
                checks++;
                if (tick_s !== 1'b1) begin
                    failures++;
                    $display("FAIL corner_tick got=%b exp=1", tick_s);
                end
            end
        end
        checks++;
        if ({px_s, py_s, act_s, actd_s} !== {10'd0, 9'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL past_corner got=x%0d y%0d a%b ad%b exp=x0 y0 a0 ad1",
                     px_s, py_s, act_s, actd_s);
        end
        rst_s = 1'b1;
        step();
        checks++;
        if (obs_s !== RST_VEC) begin
            failures++;
            $display("FAIL scaled_rereset got=%h exp=%h", obs_s, RST_VEC);
        end
    endtask

    task automatic test_frame();
        int fs_cnt, fs_first, fs_second, vs_low, vs_first;
        logic [24:0] e;
        fs_cnt = 0; fs_first = 0; fs_second = 0; vs_low = 0; vs_first = 0;
        rst_s = 1'b0;
        while (n_s < 1450) begin
            step();
            e = exp_vec(n_s, 1'b1);
            checks++;
            if (obs_s !== e) begin
                failures++;
                $display("FAIL frame_vec n=%0d got=%h exp=%h", n_s, obs_s, e);
            end
            if (fs_s === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = n_s;
                if (fs_cnt == 2) fs_second = n_s;
            end
            if (vsd_s === 1'b0) begin
                vs_low++;
                if (vs_first == 0) vs_first = n_s;
            end
        end
        checks++;
        if (fs_cnt != 2) begin
            failures++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
        checks++;
        if (fs_first != 720 || fs_second != 1440) begin
            failures++;
            $display("FAIL frame_start_times got=%0d,%0d exp=720,1440", fs_first, fs_second);
        end
        checks++;
        if (vs_low != 240) begin
            failures++;
            $display("FAIL vsync_width got=%0d exp=240", vs_low);
        end
        checks++;
        if (vs_first != 482) begin
            failures++;
            $display("FAIL vsync_start got=%0d exp=482", vs_first);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_d      = 0;
        n_s      = 0;
        rst_d    = 1'b1;
        rst_s    = 1'b1;
        test_reset();
        test_pixel_tick();
        test_line();
        test_reset_mid_line();
        test_last_pixel();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
